// File: rtl/pci_arb_pkg.sv
// Shared types and defaults for the round-robin PCI bus arbiter.
package pci_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        PARK,
        SWITCH
    } arb_state_t;

    localparam int DEF_START_TIMEOUT = 16;
    localparam int DEF_MAX_HOLD      = 64;

    // $clog2 that never yields a zero-width result.
    function automatic int clog2_safe(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// Rotate-priority encoder: first active request at or after ptr, wrapping around.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);

    logic [W-1:0] idx;

    // Scan from the far end back towards ptr so the closest request wins last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = W'((int'(ptr) + off) % N);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter_rr.sv
// N-master PCI arbiter: round-robin grants, bus parking, start-timeout and hold-time revocation.
module pci_arbiter_rr
    import pci_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int PARK_MASTER   = 0,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int MAX_HOLD      = DEF_MAX_HOLD
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_MASTERS-1:0]         req_n,
    input  logic                           frame_n,
    input  logic                           irdy_n,
    output logic [NUM_MASTERS-1:0]         gnt_n,
    output logic [$clog2(NUM_MASTERS)-1:0] gnt_id,
    output logic                           gnt_valid,
    output logic                           bus_idle
);

    localparam int ID_W  = $clog2(NUM_MASTERS);
    localparam int CNT_W = clog2_safe((START_TIMEOUT > MAX_HOLD) ? START_TIMEOUT : MAX_HOLD) + 1;
    localparam logic [ID_W-1:0] PARK_ID = ID_W'(PARK_MASTER);

    arb_state_t             state, state_nxt;
    logic [ID_W-1:0]        rr_ptr, rr_ptr_nxt, gnt_id_nxt, winner, ptr_after;
    logic [CNT_W-1:0]       start_cnt, start_nxt, start_cur;
    logic [CNT_W-1:0]       hold_cnt, hold_nxt, hold_cur;
    logic                   frame_seen, seen_nxt, seen_now;
    logic                   gnt_valid_nxt, any_req, others_req, revoke;
    logic [NUM_MASTERS-1:0] req, holder_mask;

    assign req = ~req_n;

    rr_pick #(
        .N(NUM_MASTERS),
        .W(ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (winner),
        .any_req(any_req)
    );

    assign ptr_after   = (winner == ID_W'(NUM_MASTERS - 1)) ? '0 : winner + ID_W'(1);
    assign holder_mask = NUM_MASTERS'(1) << gnt_id;
    assign others_req  = |(req & ~holder_mask);

    // Counters include the current cycle, so a timeout fires at the end of cycle N of the grant.
    assign seen_now  = frame_seen | ~frame_n;
    assign start_cur = (bus_idle && !seen_now && start_cnt != '1) ? start_cnt + CNT_W'(1) : start_cnt;
    assign hold_cur  = (hold_cnt != '1) ? hold_cnt + CNT_W'(1) : hold_cnt;
    assign revoke    = (req_n[gnt_id] & frame_n)
                     | (start_cur >= CNT_W'(START_TIMEOUT))
                     | ((hold_cur >= CNT_W'(MAX_HOLD)) & others_req);

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        start_nxt     = '0;
        hold_nxt      = '0;
        seen_nxt      = 1'b0;
        case (state)
            IDLE, SWITCH: begin
                gnt_valid_nxt = 1'b1;
                if (any_req) begin
                    state_nxt  = GRANT;
                    gnt_id_nxt = winner;
                    rr_ptr_nxt = ptr_after;
                end else begin
                    state_nxt  = PARK;
                    gnt_id_nxt = PARK_ID;
                end
            end
            PARK: begin
                if (any_req && winner == PARK_ID) begin
                    state_nxt  = GRANT;
                    rr_ptr_nxt = ptr_after;
                end else if (any_req) begin
                    state_nxt     = SWITCH;
                    gnt_valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                start_nxt = start_cur;
                hold_nxt  = hold_cur;
                seen_nxt  = seen_now;
                if (revoke) begin
                    state_nxt     = SWITCH;
                    gnt_valid_nxt = 1'b0;
                    start_nxt     = '0;
                    hold_nxt      = '0;
                    seen_nxt      = 1'b0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // Grant outputs are registered from the next-state decision so they stay glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_id     <= '0;
            gnt_valid  <= 1'b0;
            gnt_n      <= '1;
            bus_idle   <= 1'b0;
            start_cnt  <= '0;
            hold_cnt   <= '0;
            frame_seen <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            gnt_id     <= gnt_id_nxt;
            gnt_valid  <= gnt_valid_nxt;
            gnt_n      <= gnt_valid_nxt ? ~(NUM_MASTERS'(1) << gnt_id_nxt) : '1;
            bus_idle   <= frame_n & irdy_n;
            start_cnt  <= start_nxt;
            hold_cnt   <= hold_nxt;
            frame_seen <= seen_nxt;
        end
    end

endmodule

// File: doc/pci_arbiter_rr.md
Name: pci_arbiter_rr

Overview:
- Parametrised successor to the fixed 4-master PCI arbiter: N masters, active-low REQ#/GNT# vectors, fair round-robin, bus parking and fairness/timeout revocation.
- Sits beside the PCI bus core.
- Watches FRAME#/IRDY# so it can drop a grant from a master that never starts, or one that hogs the bus while others wait.

Parameters:
- NUM_MASTERS, 4: number of request/grant pairs, 2..16.
- PARK_MASTER, 0: master index parked on when no requests are pending.
- START_TIMEOUT, 16: idle-bus cycles a granted master has to assert FRAME# before the grant is revoked.
- MAX_HOLD, 64: cycles a master may keep GNT# while any other master requests.

Ports:
- clk  in  1  bus clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_n  in  NUM_MASTERS  active-low requests, bit i = master i
- frame_n  in  1  PCI FRAME#, active low
- irdy_n  in  1  PCI IRDY#, active low
- gnt_n  out  NUM_MASTERS  active-low grants, registered
- gnt_id  out  $clog2(NUM_MASTERS)  index of the current grant holder, valid when gnt_valid=1
- gnt_valid  out  1  a grant (request or park) is asserted
- bus_idle  out  1  registered, frame_n & irdy_n both high last cycle

Behaviour:
- Reset (asynchronous):
  - gnt_n = all ones, gnt_id = 0, gnt_valid = 0, bus_idle = 0.
  - state = IDLE, rr_ptr = 0, counters = 0.
- Invariant: at most one gnt_n bit is low in any cycle.
- States: IDLE, GRANT, PARK, SWITCH.
- IDLE, one cycle after reset release:
  - Any request: grant the round-robin winner, go to GRANT.
  - No request: assert gnt_n[PARK_MASTER] low, go to PARK.
- Round-robin winner: the first i with req_n[i]=0, scanning from rr_ptr up to NUM_MASTERS-1 and then wrapping to 0. On each grant, rr_ptr := winner+1 mod NUM_MASTERS.
- PARK:
  - Any request (including from PARK_MASTER) goes to SWITCH, unless the winner is PARK_MASTER; then go straight to GRANT with gnt_n unchanged.
- GRANT, holder h; revoke (go to SWITCH) when the first of these applies:
  - (a) req_n[h]=1 and frame_n=1: holder released and not mid-transaction start.
  - (b) start_cnt reaches START_TIMEOUT. start_cnt counts cycles with bus_idle=1 and no FRAME# assertion seen since the grant.
  - (c) hold_cnt reaches MAX_HOLD while any other req_n bit is low. hold_cnt counts every GRANT cycle.
- Revocation never aborts a bus transaction; the master finishes under the latency-timer rules.
- SWITCH: all gnt_n high for exactly one cycle (turnaround). Next cycle re-enter GRANT with a new winner, or PARK if there are no requests.
- Hidden arbitration: a new grant may be asserted while the bus is busy; the master waits for bus idle itself.
- Timeout-revoked master: rr_ptr has already advanced past it, so it is arbitrated last in the next round. Its request is not masked.
- Counter widths: $clog2(max(START_TIMEOUT,MAX_HOLD))+1, saturating, cleared on every new grant.
- Simultaneous holder release and timeout: treated as one revocation, a single SWITCH cycle.
- Reset asserted mid-grant: gnt_n goes all high immediately (asynchronous).
- gnt_id/gnt_valid track gnt_n in the same cycle. gnt_valid=0 in IDLE and SWITCH.

Decomposition:
- Shared package pci_arb_pkg:
  - state enum (IDLE, GRANT, PARK, SWITCH)
  - function clog2_safe
  - default timeout constants
- One natural sub-module: rr_pick, a combinational rotate-priority encoder (req vector, rr_ptr -> winner index, any_req).
- The FSM and counters stay in the top level.

Test Plan:
- Reset release, all req_n=1111: after 1 IDLE cycle, gnt_n=1110 (park on master 0), gnt_valid=1.
- Park on 0, req_n=0111 (master 3) in cycle t: t+1 gnt_n=1111 (SWITCH), t+2 gnt_n=0111, gnt_id=3.
- All four requesting continuously, each asserting FRAME# 2 cycles after grant and releasing after 8: grants rotate 0,1,2,3,0, each separated by one all-high cycle.
- Master 2 granted, FRAME# never asserted, bus idle: revoked after 16 cycles, SWITCH, grant passes to next requester 3.
- Master 1 holds with FRAME# low continuously while master 0 requests: at hold_cnt=64, gnt_n[1] goes high, SWITCH, gnt_n[0] low; frame_n unaffected.
- reset_n pulsed low for 3 ns mid-GRANT: gnt_n=1111 within the same cycle; on release, the rotation restarts from master 0.
